seq_alu_accum: RTL and testbench

//  Parametrised ALU with a 2*WIDTH-bit accumulator; operand B is always acc[WIDTH-1:0].
//  Ops are issued with a valid/ready handshake. All ops are single-cycle except MUL,

---
 rtl/alu_pkg.sv | 28 ++
 rtl/seq_mult.sv | 66 ++++++
 rtl/seq_alu_accum.sv | 136 +++++++++++++
 tb/tb_seq_alu_accum.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU/accumulator block.
//   alu_op_e    : 3-bit operation codes accepted on op_code
//   alu_state_e : top-level control state (IDLE accepts ops, BUSY runs MUL)
//   mult_cnt_w  : width of the shift-add step counter for a given operand width
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_XOROR  = 3'd2,
    OP_ANYNZ  = 3'd3,
    OP_SHL    = 3'd4,
    OP_MUL    = 3'd5,
    OP_ACCADD = 3'd6,
    OP_HOLD   = 3'd7
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

  // Counter must hold WIDTH-1 down to 1.
  function automatic int unsigned mult_cnt_w(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_mult.sv
// Iterative shift-add unsigned multiplier.
// The first partial product is taken on the start edge, the remaining WIDTH-1
// steps run on the following edges, and done pulses for one cycle once the
// product register holds the final result (so a consumer sampling on done
// writes the product exactly WIDTH edges after start).
// Ports:
//   Clock    in   1        posedge clock
//   Reset_b  in   1        synchronous active-low reset, abandons any run
//   start    in   1        load operands and begin
//   a        in   WIDTH    multiplicand
//   b        in   WIDTH    multiplier
//   product  out  2*WIDTH  running / final product
//   done     out  1        one-cycle pulse, product is final
module seq_mult
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset_b,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned CNT_W = mult_cnt_w(WIDTH);

  logic [ACC_W-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  // Shift-add datapath and step counter.
  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product <= b[0] ? ACC_W'(a) : '0;
        mcand   <= ACC_W'(a) << 1;
        mplier  <= b >> 1;
        cnt     <= CNT_W'(WIDTH - 1);
        busy    <= 1'b1;
      end else if (busy) begin
        product <= product + (mplier[0] ? mcand : '0);
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        cnt     <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_alu_accum.sv
// Sequential ALU with a 2*WIDTH-bit accumulator. Operand B is always the low
// half of acc. Single-cycle ops write acc on the accepting edge; MUL hands off
// to seq_mult and writes acc WIDTH edges after acceptance, holding op_ready low
// meanwhile (requests during that window are dropped, not queued).
// Build option: define ALU_SAT_EN to make ADD, SUB and ACCADD saturate instead
// of wrapping.
// Ports:
//   Clock     in   1        posedge clock
//   Reset_b   in   1        synchronous active-low reset, aborts MUL
//   op_valid  in   1        op request
//   op_code   in   3        operation (alu_op_e)
//   a         in   WIDTH    operand A
//   cin       in   1        carry-in for ADD
//   op_ready  out  1        op can be accepted this cycle
//   done      out  1        acc was updated at the preceding edge
//   acc       out  2*WIDTH  accumulator
module seq_alu_accum
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset_b,
  input  logic                 op_valid,
  input  logic [2:0]           op_code,
  input  logic [WIDTH-1:0]     a,
  input  logic                 cin,
  output logic                 op_ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   acc
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned SUM_W = WIDTH + 1;
  localparam logic [ACC_W-1:0] ANYNZ_VAL = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};

  alu_state_e       state;
  alu_op_e          op_c;
  logic             accept_c;
  logic             mul_start_c;
  logic [WIDTH-1:0] b_c;
  logic [SUM_W-1:0] sum_c;
  logic [SUM_W-1:0] diff_c;
  logic [WIDTH-1:0] shl_c;
  logic [ACC_W-1:0] alu_result_c;
  logic [ACC_W-1:0] mult_product;
  logic             mult_done;

  assign op_c        = alu_op_e'(op_code);
  assign accept_c    = op_valid & op_ready;
  assign mul_start_c = accept_c & (op_c == OP_MUL);
  assign b_c         = acc[WIDTH-1:0];

  // Shared arithmetic; diff_c[WIDTH] is the borrow.
  assign sum_c  = SUM_W'(a) + SUM_W'(b_c) + SUM_W'(cin);
  assign diff_c = SUM_W'(a) - SUM_W'(b_c);
  assign shl_c  = (32'(a) >= WIDTH) ? '0 : (b_c << a);

`ifdef ALU_SAT_EN
  logic [ACC_W:0] acc_sum_c;
  assign acc_sum_c = (ACC_W+1)'(acc) + (ACC_W+1)'(a);
`else
  logic [ACC_W-1:0] acc_sum_c;
  assign acc_sum_c = acc + ACC_W'(a);
`endif

  // Result of the single-cycle ops; MUL and HOLD leave acc as is.
  always_comb begin
    alu_result_c = acc;
    case (op_c)
`ifdef ALU_SAT_EN
      OP_ADD:    alu_result_c = sum_c[WIDTH] ? ACC_W'({WIDTH{1'b1}}) : ACC_W'(sum_c);
      OP_SUB:    alu_result_c = diff_c[WIDTH] ? '0 : ACC_W'(diff_c[WIDTH-1:0]);
      OP_ACCADD: alu_result_c = acc_sum_c[ACC_W] ? '1 : acc_sum_c[ACC_W-1:0];
`else
      OP_ADD:    alu_result_c = ACC_W'(sum_c);
      OP_SUB:    alu_result_c = ACC_W'(diff_c);
      OP_ACCADD: alu_result_c = acc_sum_c;
`endif
      OP_XOROR:  alu_result_c = {a ^ b_c, a | b_c};
      OP_ANYNZ:  alu_result_c = (|{a, b_c}) ? ANYNZ_VAL : '0;
      OP_SHL:    alu_result_c = {a, shl_c};
      default:   alu_result_c = acc;
    endcase
  end

  seq_mult #(
    .WIDTH (WIDTH)
  ) u_mult (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .start   (mul_start_c),
    .a       (a),
    .b       (b_c),
    .product (mult_product),
    .done    (mult_done)
  );

  // Control FSM and accumulator register.
  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      state    <= IDLE;
      op_ready <= 1'b1;
      done     <= 1'b0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            if (op_c == OP_MUL) begin
              state    <= BUSY;
              op_ready <= 1'b0;
            end else begin
              acc  <= alu_result_c;
              done <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (mult_done) begin
            acc      <= mult_product;
            done     <= 1'b1;
            state    <= IDLE;
            op_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_accum.sv
// Directed self-checking bench for seq_alu_accum at WIDTH=4.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_seq_alu_accum;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 4;

`ifdef ALU_SAT_EN
  localparam logic [7:0] EXP_ADD_F1 = 8'h0F;
  localparam logic [7:0] EXP_SUB    = 8'h00;
  localparam logic [7:0] EXP_XOR_F  = 8'hFF;
  localparam logic [7:0] EXP_ADD_FF = 8'h0F;
  localparam logic [7:0] EXP_ACCOVF = 8'hFF;
`else
  localparam logic [7:0] EXP_ADD_F1 = 8'h11;
  localparam logic [7:0] EXP_SUB    = 8'h1D;
  localparam logic [7:0] EXP_XOR_F  = 8'h2F;
  localparam logic [7:0] EXP_ADD_FF = 8'h1F;
  localparam logic [7:0] EXP_ACCOVF = 8'h01;
`endif

  logic       Clock;
  logic       Reset_b;
  logic       op_valid;
  logic [2:0] op_code;
  logic [3:0] a;
  logic       cin;
  logic       op_ready;
  logic       done;
  logic [7:0] acc;

  int checks   = 0;
  int failures = 0;

  seq_alu_accum #(.WIDTH(WIDTH)) dut (
    .Clock    (Clock),
    .Reset_b  (Reset_b),
    .op_valid (op_valid),
    .op_code  (op_code),
    .a        (a),
    .cin      (cin),
    .op_ready (op_ready),
    .done     (done),
    .acc      (acc)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input alu_op_e op, input logic [3:0] av, input logic c);
    op_valid = 1'b1;
    op_code  = op;
    a        = av;
    cin      = c;
  endtask

  // Issue one single-cycle op, drop valid, and check acc plus the done pulse.
  task automatic single(input string tag, input alu_op_e op, input logic [3:0] av,
                        input logic c, input logic [7:0] exp);
    drive(op, av, c);
    tick();
    op_valid = 1'b0;
    check(tag, 32'(acc), 32'(exp));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_rdy"}, 32'(op_ready), 32'd1);
  endtask

  initial begin
    Reset_b  = 1'b0;
    op_valid = 1'b0;
    op_code  = '0;
    a        = '0;
    cin      = 1'b0;
    tick();
    tick();
    check("rst_acc", 32'(acc), 32'h00);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdy", 32'(op_ready), 32'd1);
    Reset_b = 1'b1;

    // Reset in the middle of a MUL
    single("pre_add", OP_ADD, 4'h3, 1'b0, 8'h03);
    drive(OP_MUL, 4'hF, 1'b0);
    tick();
    op_valid = 1'b0;
    check("rmul_rdy0", 32'(op_ready), 32'd0);
    tick();
    check("rmul_rdy1", 32'(op_ready), 32'd0);
    Reset_b = 1'b0;
    tick();
    Reset_b = 1'b1;
    check("rmul_acc", 32'(acc), 32'h00);
    check("rmul_done", 32'(done), 32'd0);
    check("rmul_rdy", 32'(op_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rmul_nodone", 32'(done), 32'd0);
      check("rmul_hold", 32'(acc), 32'h00);
    end

    // ADD with carry-in, single done pulse
    single("add_01", OP_ADD, 4'h1, 1'b0, 8'h01);
    single("add_f1", OP_ADD, 4'hF, 1'b1, EXP_ADD_F1);
    tick();
    check("add_pulse", 32'(done), 32'd0);
    check("add_keep", 32'(acc), 32'(EXP_ADD_F1));

    // MUL latency and ignored request while busy
    single("anynz_a", OP_ANYNZ, 4'h0, 1'b0, 8'h81);
    single("add_0d", OP_ADD, 4'hC, 1'b0, 8'h0D);
    drive(OP_MUL, 4'hF, 1'b0);
    tick();
    check("mul_rdy_k", 32'(op_ready), 32'd0);
    check("mul_done_k", 32'(done), 32'd0);
    drive(OP_ADD, 4'h1, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("mul_busy_rdy", 32'(op_ready), 32'd0);
      check("mul_busy_acc", 32'(acc), 32'h0D);
      check("mul_busy_done", 32'(done), 32'd0);
    end
    tick();
    op_valid = 1'b0;
    check("mul_acc", 32'(acc), 32'hC3);
    check("mul_done", 32'(done), 32'd1);
    check("mul_rdy", 32'(op_ready), 32'd1);
    tick();
    check("mul_noqueue", 32'(acc), 32'hC3);
    check("mul_pulse", 32'(done), 32'd0);

    // Shifts, including amount >= WIDTH
    single("shl_2", OP_SHL, 4'd2, 1'b0, 8'h2C);
    single("shl_5", OP_SHL, 4'd5, 1'b0, 8'h50);

    // SUB with borrow, ADD overflow
    single("add_05", OP_ADD, 4'h5, 1'b0, 8'h05);
    single("sub", OP_SUB, 4'h2, 1'b0, EXP_SUB);
    single("xoror_f", OP_XOROR, 4'hF, 1'b0, EXP_XOR_F);
    single("add_ff1", OP_ADD, 4'hF, 1'b1, EXP_ADD_FF);

    // Back-to-back XOROR / ANYNZ / HOLD
    single("anynz_b", OP_ANYNZ, 4'h0, 1'b0, 8'h81);
    single("add_05b", OP_ADD, 4'h4, 1'b0, 8'h05);
    drive(OP_XOROR, 4'hA, 1'b0);
    tick();
    check("b2b_xor", 32'(acc), 32'hFF);
    check("b2b_xor_done", 32'(done), 32'd1);
    check("b2b_xor_rdy", 32'(op_ready), 32'd1);
    drive(OP_ANYNZ, 4'h0, 1'b0);
    tick();
    check("b2b_any", 32'(acc), 32'h81);
    check("b2b_any_done", 32'(done), 32'd1);
    drive(OP_HOLD, 4'h7, 1'b1);
    tick();
    op_valid = 1'b0;
    check("b2b_hold", 32'(acc), 32'h81);
    check("b2b_hold_done", 32'(done), 32'd1);

    // Accumulate, overflow, zero detect
    single("accadd", OP_ACCADD, 4'hF, 1'b0, 8'h90);
    single("xoror_ff", OP_XOROR, 4'hF, 1'b0, 8'hFF);
    single("accadd_ovf", OP_ACCADD, 4'h2, 1'b0, EXP_ACCOVF);
    single("shl_4", OP_SHL, 4'd4, 1'b0, 8'h40);
    single("anynz_zero", OP_ANYNZ, 4'h0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
